// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract block.
package nibble_serial_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width of the nibble index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_if.sv
// Operand request (valid/ready) and result (valid/ready) bundle.
interface nibble_serial_addsub_if #(
  parameter int unsigned NIBBLES = 4
) ();
  localparam int unsigned Width = 4 * NIBBLES;

  logic             in_valid;
  logic             in_ready;
  logic [Width-1:0] in_a;
  logic [Width-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [Width-1:0] out_sum;
  logic             out_carry;
  logic             out_ovf;
  logic             out_zero;

  // Source/consumer side.
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );

  // Arithmetic block side.
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_ovf, out_zero
  );
endinterface

// File: rtl/nibble_serial_addsub_slice.sv
// Combinational 4-bit add/subtract slice: {cout, s} = a + (b ^ {4{sub}}) + cin.
module addsub_slice4
  import nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                sub_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                cout_o
);
  // 5-bit arithmetic so the carry is never truncated.
  always_comb begin
    {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i ^ {NIBBLE_W{sub_i}}} + {{NIBBLE_W{1'b0}}, cin_i};
  end
endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial WIDTH-bit adder/subtractor built around one 4-bit slice.
// Optional: define NIBBLE_SERIAL_SAT_EN to saturate signed-overflowing results.
module nibble_serial_addsub
  import nibble_serial_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_addsub_if.slave  bus
);
  localparam int unsigned Width = NIBBLE_W * NIBBLES;
  localparam int unsigned IdxW  = idx_width(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [Width-1:0]  a_q, a_d;
  logic [Width-1:0]  b_q, b_d;
  logic              sub_q, sub_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [Width-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
  logic                c_nib;

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];
  end

  addsub_slice4 u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .sub_i  (sub_q),
    .cin_i  (carry_q),
    .s_o    (s_nib),
    .cout_o (c_nib)
  );

  // Next-state: capture in IDLE, one nibble per cycle in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          sub_d   = bus.in_sub;
          carry_d = bus.in_sub; // +1 of the two's-complement negate
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = s_nib;
        carry_d = c_nib;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d  = '0;
          cout_d = c_nib;
          // Sign bits of A, effective B and result all live in the MSB nibble.
          ovf_d  = (a_nib[NIBBLE_W-1] == (b_nib[NIBBLE_W-1] ^ sub_q)) &&
                   (s_nib[NIBBLE_W-1] != a_nib[NIBBLE_W-1]);
`ifdef NIBBLE_SERIAL_SAT_EN
          if (ovf_d) begin
            sum_d = a_nib[NIBBLE_W-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
          end
`endif
          zero_d  = (sum_d == '0);
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Handshake and result outputs decode directly from registered state.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.out_sum   = sum_q;
    bus.out_carry = cout_q;
    bus.out_ovf   = ovf_q;
    bus.out_zero  = zero_q;
  end
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Self-checking bench for nibble_serial_addsub with a whole-word reference model.
module tb_nibble_serial_addsub;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nibble_serial_addsub_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int lit_tag = -1;
  exp_t lit_exp;

  always @(posedge clk) cyc <= cyc + 1;

  // Whole-word arithmetic reference.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    exp_t r;
    logic [W-1:0] be;
    logic [W:0]   full;
    be = b ^ {W{sub}};
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, sub};
    r.sum = full[W-1:0];
    r.carry = full[W];
    r.ovf = (a[W-1] == be[W-1]) && (r.sum[W-1] != a[W-1]);
`ifdef NIBBLE_SERIAL_SAT_EN
    if (r.ovf) r.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o, input logic z);
    exp_t r;
    r.sum = s; r.carry = c; r.ovf = o; r.zero = z;
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return r[W-1:0];
    endcase
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Compare process: model state and all comparisons live here.
  logic m_busy = 1'b0;
  int   m_acc = 0;
  int   m_tag = -1;
  exp_t m_exp;

  always begin : compare
    logic exp_rdy, exp_vld;
    @(negedge clk or posedge rst);
    if (rst) begin
      #1;
      chk("reset_in_ready", 128'(bus.in_ready), 128'(1'b1));
      chk("reset_out_valid", 128'(bus.out_valid), 128'(1'b0));
      chk("reset_outputs", 128'({bus.out_sum, bus.out_carry, bus.out_ovf, bus.out_zero}), 128'(0));
      m_busy = 1'b0;
    end else begin
      exp_rdy = !m_busy;
      exp_vld = m_busy && (cyc >= m_acc + int'(NIBBLES));
      chk("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(bus.out_valid), 128'(exp_vld));
      if (exp_vld && bus.out_valid) begin
        chk("out_sum", 128'(bus.out_sum), 128'(m_exp.sum));
        chk("out_carry", 128'(bus.out_carry), 128'(m_exp.carry));
        chk("out_ovf", 128'(bus.out_ovf), 128'(m_exp.ovf));
        chk("out_zero", 128'(bus.out_zero), 128'(m_exp.zero));
        if (m_tag == lit_tag)
          chk("literal_result", 128'({bus.out_sum, bus.out_carry, bus.out_ovf, bus.out_zero}),
              128'(lit_exp));
      end
      if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1'b1;
          m_acc  = cyc + 1;
          m_exp  = model(bus.in_a, bus.in_b, bus.in_sub);
          m_tag  = n_acc;
          n_acc  = n_acc + 1;
        end
      end else if (exp_vld && bus.out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Present one request and hold it until it is taken (bounded).
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input exp_t e);
    @(posedge clk); #1;
    lit_exp = e;
    lit_tag = n_acc;
    bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = rnd_op(); bus.in_b = rnd_op(); bus.in_sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
  endtask

  initial begin : stim
    logic took;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    send(16'h1234, 16'h0FFF, 1'b0, mk(16'h2233, 1'b0, 1'b0, 1'b0)); wait_out();
    send(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1)); wait_out();
    send(16'h0001, 16'h0002, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0)); wait_out();
`ifdef NIBBLE_SERIAL_SAT_EN
    send(16'h8000, 16'h0001, 1'b1, mk(16'h8000, 1'b1, 1'b1, 1'b0)); wait_out();
`else
    send(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0)); wait_out();
`endif

    // Backpressure: result held while a new request waits to be accepted.
    @(posedge clk); #1 bus.out_ready = 1'b0;
    send(16'h4321, 16'h1111, 1'b0, mk(16'h5432, 1'b0, 1'b0, 1'b0)); wait_out();
    @(posedge clk); #1;
    lit_tag = n_acc;
    lit_exp = mk(16'h0095, 1'b1, 1'b0, 1'b0);
    bus.in_a = 16'h00A0; bus.in_b = 16'h000B; bus.in_sub = 1'b1; bus.in_valid = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_out();

    // Asynchronous reset while at nibble index 2.
    send(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #5 rst = 1'b0;
    send(16'h0005, 16'h0003, 1'b0, mk(16'h0008, 1'b0, 1'b0, 1'b0)); wait_out();

    // Randomized traffic with random consumer backpressure.
    lit_tag = -1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (took || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 2) != 0);
        bus.in_a = rnd_op();
        bus.in_b = rnd_op();
        bus.in_sub = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
